// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Two-master, one-slave Wishbone arbiter. Master 0 is normally the CPU and
// master 1 a secondary requester (DMA engine, debug port). Ties go
// round-robin. A grant is held for the whole cyc cycle, so multi-phase bursts
// are never split. A watchdog aborts slave cycles that keep strobing without
// any answer. The aborted master is then locked out until it drops cyc, so a
// wedged master cannot starve the other one.
//
// Parameters
//   DAT_WIDTH       width of address and data buses
//   TIMEOUT_CYCLES  consecutive unanswered strobe cycles before abort
//                   (0 disables the watchdog)
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   mN_cyc_i/stb_i/we_i       master N bus request
//   mN_sel_i/adr_i/dat_i      master N byte select, address, write data
//   mN_dat_o/ack_o/err_o      master N read data and termination
//   s_cyc_o ... s_dat_o       request to the slave side
//   s_dat_i/ack_i/err_i       slave read data and termination
//   grant_o                   one-hot current grant (debug only)
//   timeout_o                 one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DAT_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [7:0]           m0_sel_i,
  input  logic [DAT_WIDTH-1:0] m0_adr_i,
  input  logic [DAT_WIDTH-1:0] m0_dat_i,
  output logic [DAT_WIDTH-1:0] m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,

  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [7:0]           m1_sel_i,
  input  logic [DAT_WIDTH-1:0] m1_adr_i,
  input  logic [DAT_WIDTH-1:0] m1_dat_i,
  output logic [DAT_WIDTH-1:0] m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,

  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [7:0]           s_sel_o,
  output logic [DAT_WIDTH-1:0] s_adr_o,
  output logic [DAT_WIDTH-1:0] s_dat_o,
  input  logic [DAT_WIDTH-1:0] s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,

  output logic [1:0]           grant_o,
  output logic                 timeout_o
);

  // A zero timeout still needs a one-bit counter so the declarations stay legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WDOG_ON = (TIMEOUT_CYCLES > 0);
  // Abort is decided in the cycle whose unanswered strobe would bring the
  // count up to TIMEOUT_CYCLES, so the compare is against one less.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_grant_q, last_grant_d;   // index of the last tie winner
  logic [1:0]       blocked_q, blocked_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_idx_q, abort_idx_d;     // master that gets the abort error

  logic [1:0]       eligible;
  logic             sel1;
  logic             stall;

  assign eligible = {m1_cyc_i & ~blocked_q[1], m0_cyc_i & ~blocked_q[0]};
  assign sel1     = (state_q == BUSY1);

  // Read data is broadcast; only the ack/err qualifiers are steered.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = grant_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    // A block is released by any cycle in which that master's cyc is low.
    blocked_d    = blocked_q & {m1_cyc_i, m0_cyc_i};
    cnt_d        = cnt_q;
    abort_idx_d  = abort_idx_q;
    stall        = 1'b0;

    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    timeout_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (&eligible) begin
          // Tie: the master that did not win the previous tie goes first.
          state_d      = last_grant_q ? BUSY0 : BUSY1;
          last_grant_d = ~last_grant_q;
        end else if (eligible[0]) begin
          state_d = BUSY0;
        end else if (eligible[1]) begin
          state_d = BUSY1;
        end
      end

      BUSY0, BUSY1: begin
        s_cyc_o  = sel1 ? m1_cyc_i : m0_cyc_i;
        s_stb_o  = sel1 ? m1_stb_i : m0_stb_i;
        s_we_o   = sel1 ? m1_we_i  : m0_we_i;
        s_sel_o  = sel1 ? m1_sel_i : m0_sel_i;
        s_adr_o  = sel1 ? m1_adr_i : m0_adr_i;
        s_dat_o  = sel1 ? m1_dat_i : m0_dat_i;
        m0_ack_o = ~sel1 & s_ack_i;
        m0_err_o = ~sel1 & s_err_i;
        m1_ack_o =  sel1 & s_ack_i;
        m1_err_o =  sel1 & s_err_i;

        // An ack or err in the expiry cycle clears stall, so it wins over abort.
        stall = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;

        if (!s_cyc_o) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!stall) begin
          cnt_d = '0;
        end else if (WDOG_ON && cnt_q == CNT_LAST) begin
          state_d         = ABORT;
          cnt_d           = '0;
          abort_idx_d     = sel1;
          blocked_d[sel1] = 1'b1;
        end else if (~&cnt_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ABORT: begin
        // Bus already released; terminate the stuck master with an error.
        m0_err_o  = ~abort_idx_q;
        m1_err_o  =  abort_idx_q;
        timeout_o = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase

    grant_d = {state_d == BUSY1, state_d == BUSY0};
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      blocked_q    <= 2'b00;
      cnt_q        <= '0;
      abort_idx_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      blocked_q    <= blocked_d;
      cnt_q        <= cnt_d;
      abort_idx_q  <= abort_idx_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Self-checking bench for wb_arbiter with a 4-cycle watchdog. Directed
// sequences are written as per-cycle vector tables. Each applied vector pushes
// its expected outputs onto a scoreboard queue, and the queue is popped when
// the outputs are sampled on the falling edge. The round-robin test uses
// reactive master and slave models with per-master expected-data queues.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int DW  = 64;
  localparam int TMO = 4;
  localparam logic [DW-1:0] SLV_KEY = 64'h5A5A_0000_C3C3_0000;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [7:0]    m0_sel_i;
  logic [DW-1:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic          m0_ack_o, m0_err_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [7:0]    m1_sel_i;
  logic [DW-1:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic          m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [7:0]    s_sel_o;
  logic [DW-1:0] s_adr_o, s_dat_o, s_dat_i;
  logic          s_ack_i, s_err_i;
  logic [1:0]    grant_o;
  logic          timeout_o;

  always #5 clk = ~clk;

  wb_arbiter #(.DAT_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
    .m0_sel_i (m0_sel_i), .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i),
    .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
    .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
    .m1_sel_i (m1_sel_i), .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i),
    .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
    .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),  .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),
    .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),  .s_err_i  (s_err_i),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  // One row per clock cycle. flags = {s_cyc, s_stb, m0_ack, m1_ack,
  // m0_err, m1_err, timeout}.
  typedef struct {
    logic       rst;
    logic [1:0] m0;      // {cyc, stb}
    logic [1:0] m1;      // {cyc, stb}
    logic       ack;
    logic       err;
    logic [1:0] grant;
    logic [6:0] flags;
  } vec_t;

  typedef struct {
    logic [8:0]   ctl;
    logic [264:0] dp;
  } exp_t;

  vec_t          vecs[$];
  logic [DW-1:0] rdat;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string name, input logic [271:0] act,
                       input logic [271:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] m0, input logic [1:0] m1,
                     input logic ack, input logic err, input logic [1:0] grant,
                     input logic [6:0] flags);
    vec_t v;
    v.rst = rst; v.m0 = m0; v.m1 = m1; v.ack = ack; v.err = err;
    v.grant = grant; v.flags = flags;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    exp_t exp_q[$];
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst_i    = vecs[i].rst;
      {m0_cyc_i, m0_stb_i} = vecs[i].m0;
      {m1_cyc_i, m1_stb_i} = vecs[i].m1;
      s_ack_i  = vecs[i].ack;
      s_err_i  = vecs[i].err;
      s_dat_i  = rdat;
      e.ctl = {vecs[i].grant, vecs[i].flags};
      case (vecs[i].grant)
        2'b01:   e.dp = {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, rdat, rdat};
        2'b10:   e.dp = {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, rdat, rdat};
        default: e.dp = {{DW{1'b0}}, {DW{1'b0}}, 8'h00, 1'b0, rdat, rdat};
      endcase
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s[%0d] ctl", tag, i),
            {grant_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o},
            e.ctl);
      check($sformatf("%s[%0d] data", tag, i),
            {s_adr_o, s_dat_o, s_sel_o, s_we_o, m0_dat_o, m1_dat_o}, e.dp);
    end
    vecs.delete();
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_ack_i  = 1'b0; s_err_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  // Both masters run three single-ack transfers each; zero-wait slave that
  // returns address ^ SLV_KEY. Grants must alternate starting with m0.
  task automatic run_round_robin();
    int            left0 = 3, left1 = 3, k0 = 0, k1 = 0;
    bit            drop0 = 0, drop1 = 0, act0 = 0, act1 = 0, done = 0;
    int            order_q[$];
    logic [DW-1:0] q0[$], q1[$];
    int            who, last_ack = -1;
    for (int i = 0; i < 6; i++) order_q.push_back(i % 2);
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk);
      #1;
      if (drop0) begin
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; drop0 = 0;
      end else if (left0 > 0) begin
        if (!act0) begin
          m0_adr_i = 64'h1000 + DW'(k0);
          q0.push_back(m0_adr_i ^ SLV_KEY);
          act0 = 1;
        end
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      end else begin
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      end
      if (drop1) begin
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; drop1 = 0;
      end else if (left1 > 0) begin
        if (!act1) begin
          m1_adr_i = 64'h2000 + DW'(k1);
          q1.push_back(m1_adr_i ^ SLV_KEY);
          act1 = 1;
        end
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      end else begin
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      end
      #1;
      s_ack_i = s_stb_o;
      s_dat_i = s_adr_o ^ SLV_KEY;
      @(negedge clk);
      if (m0_ack_o || m1_ack_o) begin
        who = (order_q.size() > 0) ? order_q.pop_front() : -1;
        check($sformatf("rr ack%0d owner", 5 - order_q.size()),
              {m0_ack_o, m1_ack_o}, (who == 0) ? 2'b10 : 2'b01);
        if (last_ack >= 0) check("rr ack spacing", c - last_ack, 3);
        last_ack = c;
        if (m0_ack_o) begin
          check("rr m0 data", m0_dat_o, (q0.size() > 0) ? q0.pop_front() : '0);
          left0--; k0++; act0 = 0; drop0 = 1;
        end
        if (m1_ack_o) begin
          check("rr m1 data", m1_dat_o, (q1.size() > 0) ? q1.pop_front() : '0);
          left1--; k1++; act1 = 0; drop1 = 1;
        end
      end
      done = (left0 <= 0 && left1 <= 0 && !drop0 && !drop1);
    end
    check("rr completed in budget", {done, 8'(order_q.size())}, {1'b1, 8'd0});
    s_ack_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_i    = 1'b1;
    idle_inputs();
    m0_we_i  = 1'b0; m1_we_i = 1'b0;
    m0_sel_i = 8'h0F; m1_sel_i = 8'hF0;
    m0_adr_i = 64'h0000_8000_0000_0000;
    m1_adr_i = 64'h0000_0000_0000_2222;
    m0_dat_i = 64'hA0A0_A0A0_0000_0001;
    m1_dat_i = 64'hB1B1_B1B1_0000_0002;
    s_dat_i  = '0;
    repeat (2) @(posedge clk);

    // Reset state (held while m0 requests), then a single m0 read acked in cycle 3.
    rdat = 64'h0000_0000_DEAD_BEEF;
    add(1, 2'b11, 2'b00, 0, 0, 2'b00, 7'b0000000);
    add(1, 2'b11, 2'b00, 0, 0, 2'b00, 7'b0000000);
    add(0, 2'b11, 2'b00, 0, 0, 2'b00, 7'b0000000);  // cycle 0
    add(0, 2'b11, 2'b00, 0, 0, 2'b01, 7'b1100000);  // cycle 1
    add(0, 2'b11, 2'b00, 0, 0, 2'b01, 7'b1100000);
    add(0, 2'b11, 2'b00, 1, 0, 2'b01, 7'b1110000);  // cycle 3: ack
    add(0, 2'b00, 2'b00, 0, 0, 2'b01, 7'b0000000);
    add(0, 2'b00, 2'b00, 0, 0, 2'b00, 7'b0000000);
    run_vecs("single_m0");

    do_reset();
    run_round_robin();

    // m1 holds cyc across two stb phases; m0 waits, granted 2 cycles after m1 drops.
    rdat = 64'h1111_2222_3333_4444;
    add(0, 2'b00, 2'b11, 0, 0, 2'b00, 7'b0000000);
    add(0, 2'b11, 2'b11, 1, 0, 2'b10, 7'b1101000);
    add(0, 2'b11, 2'b10, 0, 0, 2'b10, 7'b1000000);
    add(0, 2'b11, 2'b11, 1, 0, 2'b10, 7'b1101000);
    add(0, 2'b11, 2'b00, 0, 0, 2'b10, 7'b0000000);  // m1 drops cyc
    add(0, 2'b11, 2'b00, 0, 0, 2'b00, 7'b0000000);
    add(0, 2'b11, 2'b00, 1, 0, 2'b01, 7'b1110000);
    add(0, 2'b00, 2'b00, 0, 0, 2'b01, 7'b0000000);
    add(0, 2'b00, 2'b00, 0, 0, 2'b00, 7'b0000000);
    run_vecs("hold_m1");

    // Watchdog: m0 write never acked, m0 then blocked until it drops cyc.
    m0_we_i = 1'b1;
    m0_adr_i = 64'h0000_0000_0000_0444;
    rdat = 64'h0BAD_0BAD_0BAD_0BAD;
    add(0, 2'b11, 2'b00, 0, 0, 2'b00, 7'b0000000);
    add(0, 2'b11, 2'b11, 0, 0, 2'b01, 7'b1100000);
    add(0, 2'b11, 2'b11, 0, 0, 2'b01, 7'b1100000);
    add(0, 2'b11, 2'b11, 0, 0, 2'b01, 7'b1100000);
    add(0, 2'b11, 2'b11, 0, 0, 2'b01, 7'b1100000);  // 4th unanswered strobe
    add(0, 2'b11, 2'b11, 0, 0, 2'b00, 7'b0000101);  // ABORT
    add(0, 2'b11, 2'b11, 0, 0, 2'b00, 7'b0000000);
    add(0, 2'b11, 2'b11, 1, 0, 2'b10, 7'b1101000);  // m1 served
    add(0, 2'b11, 2'b00, 0, 0, 2'b10, 7'b0000000);
    add(0, 2'b11, 2'b00, 0, 0, 2'b00, 7'b0000000);  // m0 still blocked
    add(0, 2'b00, 2'b00, 0, 0, 2'b00, 7'b0000000);  // m0 drops cyc
    add(0, 2'b11, 2'b00, 0, 0, 2'b00, 7'b0000000);
    add(0, 2'b11, 2'b00, 1, 0, 2'b01, 7'b1110000);
    add(0, 2'b00, 2'b00, 0, 0, 2'b01, 7'b0000000);
    add(0, 2'b00, 2'b00, 0, 0, 2'b00, 7'b0000000);
    run_vecs("watchdog");
    m0_we_i = 1'b0;

    // Ack on the expiry cycle wins; counter restarts after each ack.
    // Then slave err on m1: plain termination, no abort.
    rdat = 64'h7777_6666_5555_4444;
    add(0, 2'b11, 2'b00, 0, 0, 2'b00, 7'b0000000);
    add(0, 2'b11, 2'b00, 0, 0, 2'b01, 7'b1100000);
    add(0, 2'b11, 2'b00, 0, 0, 2'b01, 7'b1100000);
    add(0, 2'b11, 2'b00, 0, 0, 2'b01, 7'b1100000);
    add(0, 2'b11, 2'b00, 1, 0, 2'b01, 7'b1110000);
    add(0, 2'b11, 2'b00, 0, 0, 2'b01, 7'b1100000);
    add(0, 2'b11, 2'b00, 0, 0, 2'b01, 7'b1100000);
    add(0, 2'b11, 2'b00, 0, 0, 2'b01, 7'b1100000);
    add(0, 2'b11, 2'b00, 1, 0, 2'b01, 7'b1110000);
    add(0, 2'b00, 2'b00, 0, 0, 2'b01, 7'b0000000);
    add(0, 2'b00, 2'b00, 0, 0, 2'b00, 7'b0000000);
    add(0, 2'b00, 2'b11, 0, 0, 2'b00, 7'b0000000);
    add(0, 2'b00, 2'b11, 0, 1, 2'b10, 7'b1100010);
    add(0, 2'b00, 2'b11, 1, 0, 2'b10, 7'b1101000);
    add(0, 2'b00, 2'b00, 0, 0, 2'b10, 7'b0000000);
    add(0, 2'b00, 2'b00, 0, 0, 2'b00, 7'b0000000);
    run_vecs("ack_vs_expiry");

    // Reset during a BUSY1 transfer; first tie afterwards goes to m0.
    rdat = 64'h0123_4567_89AB_CDEF;
    add(0, 2'b00, 2'b11, 0, 0, 2'b00, 7'b0000000);
    add(1, 2'b11, 2'b11, 0, 0, 2'b10, 7'b1100000);
    add(0, 2'b11, 2'b11, 0, 0, 2'b00, 7'b0000000);
    add(0, 2'b11, 2'b11, 1, 0, 2'b01, 7'b1110000);
    add(0, 2'b00, 2'b11, 0, 0, 2'b01, 7'b0000000);
    add(0, 2'b00, 2'b11, 0, 0, 2'b00, 7'b0000000);
    add(0, 2'b00, 2'b11, 1, 0, 2'b10, 7'b1101000);
    add(0, 2'b00, 2'b00, 0, 0, 2'b10, 7'b0000000);
    add(0, 2'b00, 2'b00, 0, 0, 2'b00, 7'b0000000);
    run_vecs("reset_mid");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
